// File: rtl/plc_timer_pkg.sv
// Shared encodings for the PLC timer controller: timer modes, FSM states,
// ET counter commands and the output-bit decode.
package plc_timer_pkg;

  localparam int ET_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    MODE_TON = 2'd0,
    MODE_TOF = 2'd1,
    MODE_TP  = 2'd2,
    MODE_OFF = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RUNNING = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ET_HOLD = 2'd0,
    ET_CLR  = 2'd1,
    ET_INC  = 2'd2,
    ET_LOAD = 2'd3
  } et_op_e;

  // Timer output bit as a function of mode and FSM state.
  function automatic logic q_decode(input mode_e mode, input state_e state);
    case (mode)
      MODE_TON: q_decode = (state == ST_EXPIRED);
      MODE_TOF: q_decode = (state == ST_ARMED) || (state == ST_RUNNING);
      MODE_TP:  q_decode = (state == ST_RUNNING);
      default:  q_decode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/plc_timer_et_counter.sv
// Elapsed-time register. Clear / increment / force-to-PT under FSM command,
// plus a terminal flag telling the FSM that the next tick reaches PT.
module plc_timer_et_counter
  import plc_timer_pkg::*;
#(
  parameter int ET_WIDTH = ET_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  et_op_e              op,
  input  logic [ET_WIDTH-1:0] pt,
  output logic [ET_WIDTH-1:0] et,
  output logic                terminal
);

  logic [ET_WIDTH:0] et_plus1;

  // Widened so that ET+1 compares correctly even when ET is all ones.
  assign et_plus1 = {1'b0, et} + {{ET_WIDTH{1'b0}}, 1'b1};
  assign terminal = (pt == {ET_WIDTH{1'b0}}) || (et_plus1 == {1'b0, pt});

  // ET register update under the FSM command
  always_ff @(posedge clk) begin
    if (rst) begin
      et <= {ET_WIDTH{1'b0}};
    end else begin
      case (op)
        ET_CLR:  et <= {ET_WIDTH{1'b0}};
        ET_INC:  et <= et_plus1[ET_WIDTH-1:0];
        ET_LOAD: et <= pt;
        default: et <= et;
      endcase
    end
  end

endmodule

// File: rtl/plc_timer_ctrl.sv
// IEC 61131-3 TON / TOF / TP timer controller. Gates one external prescaler,
// counts its overflow ticks into ET and drives the timer output bit.
module plc_timer_ctrl
  import plc_timer_pkg::*;
#(
  parameter int ET_WIDTH = ET_WIDTH_DEF
) (
  input  logic                CLK,
  input  logic                CPU_Reset,
  input  logic [1:0]          TIMER_CONFIG_MODE,
  input  logic [ET_WIDTH-1:0] TIMER_CONFIG_PT,
  input  logic                CFG_WE,
  input  logic                TIMER_IN,
  input  logic                PRESCALER_OV,
  output logic                TIMER_EN,
  output logic                TIMER_Q,
  output logic [ET_WIDTH-1:0] TIMER_ET,
  output logic                TIMER_DONE
);

  localparam logic [ET_WIDTH-1:0] PT_ZERO = {ET_WIDTH{1'b0}};

  state_e              state_r, state_nxt;
  mode_e               mode_r;
  logic [ET_WIDTH-1:0] pt_r;
  logic                in_d_r, done_r, done_nxt, q_r, en_r;
  et_op_e              et_op;
  logic                terminal, tick, rise;

  // Overflows only count while the prescaler is actually enabled.
  assign tick = PRESCALER_OV && en_r;
  assign rise = TIMER_IN && !in_d_r;

  plc_timer_et_counter #(.ET_WIDTH(ET_WIDTH)) u_et (
    .clk      (CLK),
    .rst      (CPU_Reset),
    .op       (et_op),
    .pt       (pt_r),
    .et       (TIMER_ET),
    .terminal (terminal)
  );

  // Next state, ET command and DONE; IN changes take priority over ticks
  always_comb begin
    state_nxt = state_r;
    et_op     = ET_HOLD;
    done_nxt  = 1'b0;
    if (CFG_WE) begin
      state_nxt = ST_IDLE;
      et_op     = ET_CLR;
    end else begin
      case (mode_r)
        MODE_TON: begin
          if (!TIMER_IN) begin
            state_nxt = ST_IDLE;
            et_op     = ET_CLR;
          end else begin
            case (state_r)
              ST_RUNNING: begin
                if (tick && terminal) begin
                  state_nxt = ST_EXPIRED;
                  et_op     = ET_LOAD;
                  done_nxt  = 1'b1;
                end else if (tick) begin
                  et_op = ET_INC;
                end else begin
                  et_op = ET_HOLD;
                end
              end
              ST_EXPIRED: state_nxt = ST_EXPIRED;
              default: begin
                et_op = ET_CLR;
                if (pt_r == PT_ZERO) begin
                  state_nxt = ST_EXPIRED;
                  done_nxt  = 1'b1;
                end else begin
                  state_nxt = ST_RUNNING;
                end
              end
            endcase
          end
        end
        MODE_TOF: begin
          if (TIMER_IN) begin
            state_nxt = ST_ARMED;
            et_op     = ET_CLR;
          end else begin
            case (state_r)
              ST_ARMED: begin
                et_op = ET_CLR;
                if (pt_r == PT_ZERO) begin
                  state_nxt = ST_IDLE;
                  done_nxt  = 1'b1;
                end else begin
                  state_nxt = ST_RUNNING;
                end
              end
              ST_RUNNING: begin
                if (tick && terminal) begin
                  state_nxt = ST_IDLE;
                  et_op     = ET_LOAD;
                  done_nxt  = 1'b1;
                end else if (tick) begin
                  et_op = ET_INC;
                end else begin
                  et_op = ET_HOLD;
                end
              end
              // ET keeps the last expired value while idle
              default: state_nxt = ST_IDLE;
            endcase
          end
        end
        MODE_TP: begin
          case (state_r)
            ST_RUNNING: begin
              if (tick && terminal) begin
                state_nxt = TIMER_IN ? ST_EXPIRED : ST_IDLE;
                et_op     = ET_LOAD;
                done_nxt  = 1'b1;
              end else if (tick) begin
                et_op = ET_INC;
              end else begin
                et_op = ET_HOLD;
              end
            end
            ST_EXPIRED: begin
              if (!TIMER_IN) begin
                state_nxt = ST_IDLE;
                et_op     = ET_CLR;
              end else begin
                state_nxt = ST_EXPIRED;
              end
            end
            ST_IDLE: begin
              if (rise) begin
                et_op = ET_CLR;
                if (pt_r == PT_ZERO) begin
                  done_nxt = 1'b1;
                end else begin
                  state_nxt = ST_RUNNING;
                end
              end else begin
                state_nxt = ST_IDLE;
              end
            end
            default: begin
              state_nxt = ST_IDLE;
              et_op     = ET_CLR;
            end
          endcase
        end
        default: begin
          state_nxt = ST_IDLE;
          et_op     = ET_CLR;
        end
      endcase
    end
  end

  // State, configuration, edge-detect and registered output bits
  always_ff @(posedge CLK) begin
    if (CPU_Reset) begin
      state_r <= ST_IDLE;
      mode_r  <= MODE_OFF;
      pt_r    <= PT_ZERO;
      in_d_r  <= 1'b0;
      done_r  <= 1'b0;
      q_r     <= 1'b0;
      en_r    <= 1'b0;
    end else begin
      in_d_r  <= TIMER_IN;
      state_r <= state_nxt;
      done_r  <= done_nxt;
      en_r    <= (state_nxt == ST_RUNNING);
      if (CFG_WE) begin
        mode_r <= mode_e'(TIMER_CONFIG_MODE);
        pt_r   <= TIMER_CONFIG_PT;
        q_r    <= 1'b0;
      end else begin
        q_r    <= q_decode(mode_r, state_nxt);
      end
    end
  end

  assign TIMER_EN   = en_r;
  assign TIMER_Q    = q_r;
  assign TIMER_DONE = done_r;

endmodule

// File: tb/tb_plc_timer_ctrl.sv
// Self-checking bench for plc_timer_ctrl: directed scenarios plus random
// traffic, all checked against a behavioural timer model.
module tb_plc_timer_ctrl;

  localparam int W = 16;

  logic         CLK = 1'b0;
  logic         rst = 1'b1;
  logic         cfg_we = 1'b0;
  logic [1:0]   cfg_mode = 2'd0;
  logic [W-1:0] cfg_pt = '0;
  logic         tin = 1'b0;
  logic         ov = 1'b0;
  logic         TIMER_EN, TIMER_Q, TIMER_DONE;
  logic [W-1:0] TIMER_ET;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int per = -1;   // >0 periodic overflow, 0 random, <0 driven by hand
  int pcnt = 0;

  // behavioural model
  logic [1:0]   m_mode;
  logic [W-1:0] m_pt, m_et;
  bit           m_in_d, m_done, m_timing, m_expired, m_armed;

  wire [W+2:0] got = {TIMER_EN, TIMER_Q, TIMER_ET, TIMER_DONE};

  plc_timer_ctrl #(.ET_WIDTH(W)) dut (
    .CLK               (CLK),
    .CPU_Reset         (rst),
    .TIMER_CONFIG_MODE (cfg_mode),
    .TIMER_CONFIG_PT   (cfg_pt),
    .CFG_WE            (cfg_we),
    .TIMER_IN          (tin),
    .PRESCALER_OV      (ov),
    .TIMER_EN          (TIMER_EN),
    .TIMER_Q           (TIMER_Q),
    .TIMER_ET          (TIMER_ET),
    .TIMER_DONE        (TIMER_DONE)
  );

  always #5 CLK = ~CLK;

  function automatic logic [W+2:0] exp_vec();
    logic q;
    case (m_mode)
      2'd0:    q = m_expired;
      2'd1:    q = m_armed || m_timing;
      2'd2:    q = m_timing;
      default: q = 1'b0;
    endcase
    return {m_timing, q, m_et, m_done};
  endfunction

  task automatic model_step();
    bit tick;
    tick   = ov && m_timing;
    m_done = 0;
    if (rst) begin
      m_mode = 2'd3; m_pt = '0; m_in_d = 0; m_et = '0;
      m_timing = 0; m_expired = 0; m_armed = 0;
    end else begin
      if (cfg_we) begin
        m_timing = 0; m_expired = 0; m_armed = 0; m_et = '0;
        m_mode = cfg_mode; m_pt = cfg_pt;
      end else begin
        case (m_mode)
          2'd0: begin
            if (!tin) begin
              m_timing = 0; m_expired = 0; m_et = '0;
            end else if (!m_timing && !m_expired) begin
              m_et = '0;
              if (m_pt == 0) begin m_expired = 1; m_done = 1; end
              else m_timing = 1;
            end else if (m_timing && tick) begin
              if (m_et + 1 == m_pt) begin
                m_timing = 0; m_expired = 1; m_et = m_pt; m_done = 1;
              end else m_et = m_et + 1'b1;
            end
          end
          2'd1: begin
            if (tin) begin
              m_armed = 1; m_timing = 0; m_et = '0;
            end else if (m_armed) begin
              m_armed = 0; m_et = '0;
              if (m_pt == 0) m_done = 1;
              else m_timing = 1;
            end else if (m_timing && tick) begin
              if (m_et + 1 == m_pt) begin
                m_timing = 0; m_et = m_pt; m_done = 1;
              end else m_et = m_et + 1'b1;
            end
          end
          2'd2: begin
            if (m_timing) begin
              if (tick) begin
                if (m_et + 1 == m_pt) begin
                  m_timing = 0; m_et = m_pt; m_done = 1; m_expired = tin;
                end else m_et = m_et + 1'b1;
              end
            end else if (m_expired) begin
              if (!tin) begin m_expired = 0; m_et = '0; end
            end else if (tin && !m_in_d) begin
              m_et = '0;
              if (m_pt == 0) m_done = 1;
              else m_timing = 1;
            end
          end
          default: begin
            m_timing = 0; m_expired = 0; m_armed = 0; m_et = '0;
          end
        endcase
      end
      m_in_d = tin;
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_step();
    #1;
    cyc++;
    if (per > 0) begin
      ov = ((pcnt % per) == per - 1);
      pcnt++;
    end else if (per == 0) begin
      ov = ($urandom_range(2, 0) == 0);
    end
  endtask

  task automatic configure(input logic [1:0] md, input logic [W-1:0] p);
    cfg_we = 1'b1; cfg_mode = md; cfg_pt = p;
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tin = 1'b1; ov = 1'b1; per = -1;
    cycle(); cycle();
    checks++;
    if (got !== '0) begin failures++; $display("FAIL reset_vals got=%h exp=0", got); end
    checks++;
    if (got !== exp_vec()) begin failures++; $display("FAIL reset_model got=%h exp=%h", got, exp_vec()); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (got !== '0) begin failures++; $display("FAIL mode3_idle cyc=%0d got=%h exp=0", cyc, got); end
    end
    tin = 1'b0; ov = 1'b0;
  endtask

  task automatic test_ton();
    int dcnt = 0;
    ov = 1'b0; per = -1;
    configure(2'd0, 16'd5);
    per = 4; pcnt = 0; tin = 1'b1;
    cycle();
    checks++;
    if (TIMER_EN !== 1'b1) begin failures++; $display("FAIL ton_en_rise got=%b exp=1", TIMER_EN); end
    for (int i = 0; i < 35; i++) begin
      cycle();
      if (TIMER_DONE === 1'b1) dcnt++;
      checks++;
      if (got !== exp_vec()) begin failures++; $display("FAIL ton_run cyc=%0d got=%h exp=%h", cyc, got, exp_vec()); end
    end
    checks++;
    if (dcnt != 1 || TIMER_Q !== 1'b1 || TIMER_ET !== 16'd5)
      begin failures++; $display("FAIL ton_expire done=%0d q=%b et=%0d exp done=1 q=1 et=5", dcnt, TIMER_Q, TIMER_ET); end
    tin = 1'b0;
    cycle();
    checks++;
    if (TIMER_Q !== 1'b0 || TIMER_ET !== 16'd0)
      begin failures++; $display("FAIL ton_fall q=%b et=%0d exp q=0 et=0", TIMER_Q, TIMER_ET); end
  endtask

  task automatic test_ton_abort();
    bit hit = 0;
    ov = 1'b0; per = -1;
    configure(2'd0, 16'd5);
    per = 4; pcnt = 0; tin = 1'b1;
    for (int i = 0; i < 30 && !hit; i++) begin
      cycle();
      checks++;
      if (got !== exp_vec()) begin failures++; $display("FAIL abort_run cyc=%0d got=%h exp=%h", cyc, got, exp_vec()); end
      if (TIMER_ET === 16'd3) hit = 1;
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL abort_wait et=%0d exp=3 within 30 cycles", TIMER_ET); end
    tin = 1'b0;
    cycle();
    checks++;
    if (got !== '0) begin failures++; $display("FAIL abort_idle got=%h exp=0", got); end
    tin = 1'b1;
    cycle();
    checks++;
    if (TIMER_EN !== 1'b1 || TIMER_ET !== 16'd0)
      begin failures++; $display("FAIL abort_restart en=%b et=%0d exp en=1 et=0", TIMER_EN, TIMER_ET); end
    for (int i = 0; i < 30; i++) begin
      cycle();
      checks++;
      if (got !== exp_vec()) begin failures++; $display("FAIL abort_rerun cyc=%0d got=%h exp=%h", cyc, got, exp_vec()); end
    end
  endtask

  task automatic test_tof();
    int dcnt = 0;
    ov = 1'b0; per = -1;
    configure(2'd1, 16'd3);
    per = 4; pcnt = 0;
    for (int i = 0; i < 38; i++) begin
      tin = (i < 3) || (i == 9) || (i == 10);
      cycle();
      if (TIMER_DONE === 1'b1) dcnt++;
      checks++;
      if (got !== exp_vec()) begin failures++; $display("FAIL tof_run cyc=%0d got=%h exp=%h", cyc, got, exp_vec()); end
    end
    checks++;
    if (dcnt != 1 || TIMER_Q !== 1'b0 || TIMER_ET !== 16'd3)
      begin failures++; $display("FAIL tof_expire done=%0d q=%b et=%0d exp done=1 q=0 et=3", dcnt, TIMER_Q, TIMER_ET); end
  endtask

  task automatic test_tp();
    int dcnt = 0;
    ov = 1'b0; per = -1; tin = 1'b0;
    configure(2'd2, 16'd4);
    per = 4; pcnt = 0;
    cycle();
    tin = 1'b1;
    cycle();
    checks++;
    if (TIMER_Q !== 1'b1) begin failures++; $display("FAIL tp_start q=%b exp=1", TIMER_Q); end
    for (int i = 0; i < 35; i++) begin
      tin = (i < 10) ? 1'($urandom_range(1, 0)) : 1'b1;
      cycle();
      if (TIMER_DONE === 1'b1) dcnt++;
      checks++;
      if (got !== exp_vec()) begin failures++; $display("FAIL tp_run cyc=%0d got=%h exp=%h", cyc, got, exp_vec()); end
    end
    checks++;
    if (dcnt != 1 || TIMER_Q !== 1'b0 || TIMER_ET !== 16'd4)
      begin failures++; $display("FAIL tp_expire done=%0d q=%b et=%0d exp done=1 q=0 et=4", dcnt, TIMER_Q, TIMER_ET); end
    tin = 1'b0;
    cycle();
    checks++;
    if (TIMER_ET !== 16'd0) begin failures++; $display("FAIL tp_release et=%0d exp=0", TIMER_ET); end
  endtask

  task automatic test_pt_zero();
    int exp_d[4] = '{1, 1, 1, 0};
    int exp_q[4] = '{4, 4, 0, 0};
    for (int m = 0; m < 4; m++) begin
      int dcnt = 0;
      int qcnt = 0;
      int ecnt = 0;
      ov = 1'b0; per = -1; tin = 1'b0;
      configure(2'(m), 16'd0);
      per = 4; pcnt = 0;
      for (int i = 0; i < 10; i++) begin
        tin = (i >= 2) && (i < 6);
        cycle();
        if (TIMER_DONE === 1'b1) dcnt++;
        if (TIMER_Q === 1'b1) qcnt++;
        if (TIMER_EN === 1'b1) ecnt++;
        checks++;
        if (got !== exp_vec()) begin failures++; $display("FAIL pt0_run mode=%0d cyc=%0d got=%h exp=%h", m, cyc, got, exp_vec()); end
      end
      checks++;
      if (dcnt != exp_d[m] || qcnt != exp_q[m] || ecnt != 0)
        begin failures++; $display("FAIL pt0_counts mode=%0d done=%0d q=%0d en=%0d exp done=%0d q=%0d en=0", m, dcnt, qcnt, ecnt, exp_d[m], exp_q[m]); end
    end
  endtask

  task automatic test_cfg_reset();
    bit hit = 0;
    int dcnt = 0;
    // reconfigure in the middle of a TON run
    ov = 1'b0; per = -1;
    configure(2'd0, 16'd5);
    per = 4; pcnt = 0; tin = 1'b1;
    for (int i = 0; i < 30 && !hit; i++) begin
      cycle();
      if (TIMER_ET === 16'd2) hit = 1;
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL cfg_wait et=%0d exp=2 within 30 cycles", TIMER_ET); end
    cfg_we = 1'b1; cfg_mode = 2'd0; cfg_pt = 16'd7;
    cycle();
    cfg_we = 1'b0;
    checks++;
    if (got !== '0) begin failures++; $display("FAIL cfg_abort got=%h exp=0", got); end
    for (int i = 0; i < 45; i++) begin
      cycle();
      if (TIMER_DONE === 1'b1) dcnt++;
      checks++;
      if (got !== exp_vec()) begin failures++; $display("FAIL cfg_rerun cyc=%0d got=%h exp=%h", cyc, got, exp_vec()); end
    end
    checks++;
    if (dcnt != 1 || TIMER_ET !== 16'd7)
      begin failures++; $display("FAIL cfg_newpt done=%0d et=%0d exp done=1 et=7", dcnt, TIMER_ET); end
    // CPU reset in the middle of a run
    configure(2'd0, 16'd5);
    tin = 1'b1;
    for (int i = 0; i < 8; i++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++;
    if (got !== '0) begin failures++; $display("FAIL rst_midrun got=%h exp=0", got); end
    cycle();
    checks++;
    if (got !== '0) begin failures++; $display("FAIL rst_mode_off got=%h exp=0", got); end
    // TON: IN falls on the expiry tick
    per = -1; ov = 1'b0;
    configure(2'd0, 16'd3);
    cycle();
    ov = 1'b1;
    cycle(); cycle();
    checks++;
    if (TIMER_ET !== 16'd2) begin failures++; $display("FAIL ton_pre_race et=%0d exp=2", TIMER_ET); end
    tin = 1'b0;
    cycle();
    checks++;
    if (got !== '0) begin failures++; $display("FAIL ton_race got=%h exp=0", got); end
    // TOF: IN rises on the expiry tick
    ov = 1'b0; tin = 1'b1;
    configure(2'd1, 16'd2);
    cycle();
    tin = 1'b0;
    cycle();
    ov = 1'b1;
    cycle();
    tin = 1'b1;
    cycle();
    checks++;
    if (TIMER_Q !== 1'b1 || TIMER_ET !== 16'd0 || TIMER_DONE !== 1'b0 || TIMER_EN !== 1'b0)
      begin failures++; $display("FAIL tof_race q=%b et=%0d done=%b en=%b exp q=1 et=0 done=0 en=0", TIMER_Q, TIMER_ET, TIMER_DONE, TIMER_EN); end
  endtask

  task automatic test_random();
    per = 0;
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(499, 0) == 0);
      cfg_we   = ($urandom_range(39, 0) == 0);
      cfg_mode = 2'($urandom_range(3, 0));
      cfg_pt   = W'($urandom_range(6, 0));
      if ($urandom_range(5, 0) == 0) tin = ~tin;
      cycle();
      checks++;
      if (got !== exp_vec()) begin failures++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, got, exp_vec()); end
    end
    rst = 1'b0; cfg_we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ton();
    test_ton_abort();
    test_tof();
    test_tp();
    test_pt_zero();
    test_cfg_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/plc_timer_ctrl.md
# plc_timer_ctrl

IEC 61131-3 style timer controller (TON / TOF / TP) that sequences the timer prescaler. It gates the prescaler enable, counts prescaler overflow ticks into an elapsed-time register, compares against a preset, and produces the PLC timer output bit. It sits between the CPU configuration/IO bits of a PLC core and one prescaler instance; one controller serves exactly one prescaler.

## Interface
- ET_WIDTH, 16, width of preset and elapsed-time values (in prescaler ticks)
- CLK  in  1  clock
- CPU_Reset  in  1  synchronous, active-high reset
- TIMER_CONFIG_MODE  in  2  0 = TON, 1 = TOF, 2 = TP, 3 = disabled; sampled on CFG_WE
- TIMER_CONFIG_PT  in  ET_WIDTH  preset time; sampled on CFG_WE
- CFG_WE  in  1  latch mode and PT, abort any running timing
- TIMER_IN  in  1  PLC timer input bit (level)
- PRESCALER_OV  in  1  overflow from prescaler
- TIMER_EN  out  1  prescaler enable
- TIMER_Q  out  1  timer output bit
- TIMER_ET  out  ET_WIDTH  elapsed time
- TIMER_DONE  out  1  one-cycle pulse on expiry

## Operation
- One clock (CLK), synchronous active-high reset (CPU_Reset).
- States: IDLE, ARMED (TOF only, IN high), RUNNING, EXPIRED.
- tick = PRESCALER_OV && TIMER_EN. PRESCALER_OV with TIMER_EN low is ignored.
- TIMER_EN = 1 only in RUNNING.
- In RUNNING, on tick: if ET+1 == PT, go to EXPIRED, set ET = PT, pulse DONE. Otherwise ET increments.
- ET never exceeds PT.
- TON:
  - IDLE with IN=1 goes to RUNNING (ET=0). If PT=0, go directly to EXPIRED with DONE.
  - IN=0 in any state goes to IDLE with ET=0.
  - Q=1 only in EXPIRED.
- TOF:
  - IN=1 in any state goes to ARMED with ET=0.
  - ARMED with IN=0 goes to RUNNING. If PT=0, go directly to IDLE with DONE and ET=0.
  - Expiry goes to IDLE with ET held at PT.
  - Q=1 in ARMED and RUNNING.
- TP:
  - IDLE goes to RUNNING on an IN rising edge (IN=1, in_d=0).
  - IN is ignored while RUNNING.
  - On expiry: if IN=1, go to EXPIRED. If IN=0, go to IDLE.
  - EXPIRED goes to IDLE with ET=0 when IN=0.
  - Q=1 only in RUNNING.
  - PT=0: the rising edge produces DONE, no Q pulse.
- Mode 3: held in IDLE; Q=0, ET=0, TIMER_EN=0.
- Priority: CPU_Reset > CFG_WE > IN change > tick.
  - TON: IN falling in the same cycle as the expiry tick goes to IDLE with no DONE.
  - TOF: IN rising in the same cycle as the expiry tick goes to ARMED with no DONE.
- CFG_WE: next cycle the state is IDLE, ET=0, DONE=0, and new mode/PT are active. IN is re-evaluated from the following cycle.

## Timing
- Reset values:
  - TIMER_EN=0, TIMER_Q=0, TIMER_ET=0, TIMER_DONE=0
  - state IDLE, mode = 3 (disabled), PT=0, in_d=0
- All state, ET, in_d and DONE are registered. Q and TIMER_EN are decoded from the state register only. There is no combinational path from any input to any output.
- IN change to state/Q change: 1 cycle.
- Tick to ET update: 1 cycle. The expiry tick updates Q and DONE in the same edge as ET=PT.
- The prescaler phase is not cleared at start. The first tick arrives 1 to (prescale+1) cycles after TIMER_EN rises. Total timing error is less than one prescaler period.
- DONE is exactly one cycle wide. Back-to-back expiries are not possible; each requires a new RUNNING entry.
- in_d updates every cycle, including in mode 3. On reset, in_d is cleared.

## Structure
- Package plc_timer_pkg:
  - mode encodings (TON/TOF/TP/OFF)
  - state encoding
  - default ET_WIDTH
- Sub-module plc_timer_et_counter: ET register with clear/increment/force-to-PT controls and a terminal flag (ET+1 == PT, or PT == 0).
- FSM and mode decode live in plc_timer_ctrl.
- The prescaler is instantiated by the parent, not inside this block.

## Test plan
- TON, PT=5, prescaler ticking every 4 cycles, IN held high → TIMER_EN rises 1 cycle after IN; ET counts 1..5; Q=1 and DONE pulses on the 5th tick; IN low → Q=0, ET=0 next cycle.
- TON, PT=5, IN dropped after 3 ticks → IDLE, ET=0, no DONE, TIMER_EN=0; re-raise IN → ET restarts from 0.
- TOF, PT=3, IN 1→0 → Q stays 1 through 3 ticks, then Q=0 with DONE and ET=3; IN pulsed high mid-run → ET=0, Q=1, restart on fall.
- TP, PT=4, IN toggled during RUNNING → Q high for exactly 4 ticks; IN held high after expiry → EXPIRED, ET=4; IN low → ET=0.
- PT=0 in each mode plus mode 3 → DONE with no Q pulse (TON: Q=1 immediately, no RUNNING); mode 3: outputs remain at reset values.
- CFG_WE mid-RUNNING (TON, ET=2) with new PT=7, plus CPU_Reset mid-run, plus TON IN fall coinciding with the expiry tick → IDLE, ET=0, no DONE in every case.
